compare_seq: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator; successor to the 4-bit combinational compare.

---
 rtl/compare_pkg.sv | 15 +
 rtl/compare_chunk.sv | 14 +
 rtl/compare_seq.sv | 121 ++++++++++++
 tb/tb_compare_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared result codes and FSM state encoding for the sequential magnitude comparator.
package compare_pkg;

    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_EQ   = 2'b01;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_LT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/compare_chunk.sv
// Combinational CHUNK-bit unsigned comparator slice; reports equality and A-greater-than-B.
module compare_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator: walks operands MSB chunk first, stops at the first difference.
// Define COMPARE_SIGNED_EN for a two's-complement compare; otherwise operands are unsigned.
module compare_seq
    import compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       c,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [1:0]         c_reg, c_next;

    logic [CHUNK-1:0]   a_chunks [NCHUNK];
    logic [CHUNK-1:0]   b_chunks [NCHUNK];
    logic [CHUNK-1:0]   sel_a, sel_b;
    logic               chunk_eq, chunk_gt;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
        assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end

    always_comb begin
        sel_a = a_chunks[idx_reg];
        sel_b = b_chunks[idx_reg];
`ifdef COMPARE_SIGNED_EN
        // Flipping the sign bits maps two's complement order onto unsigned order.
        if (idx_reg == IDX_TOP) begin
            sel_a[CHUNK-1] = ~sel_a[CHUNK-1];
            sel_b[CHUNK-1] = ~sel_b[CHUNK-1];
        end
`endif
    end

    compare_chunk #(.W(CHUNK)) u_chunk (
        .a  (sel_a),
        .b  (sel_b),
        .eq (chunk_eq),
        .gt (chunk_gt)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    idx_next   = IDX_TOP;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!chunk_eq) begin
                    c_next     = chunk_gt ? CMP_GT : CMP_LT;
                    state_next = DONE;
                end else if (idx_reg == '0) begin
                    c_next     = CMP_EQ;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    c_next     = CMP_NONE;
                    state_next = IDLE;
                end
            end
            default: begin
                c_next     = CMP_NONE;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= CMP_NONE;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
        end
    end

    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready  = rst_n && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign c         = c_reg;
    assign busy      = (state_reg == RUN) || (state_reg == DONE);

endmodule

// File: tb/tb_compare_seq.sv
// Self-checking bench for compare_seq: table-driven vectors with a scoreboard queue plus corner sequences.
module tb_compare_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  c;
    logic        busy;

    logic        rst16_n;
    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16, b16;
    logic        out_valid16;
    logic        out_ready16;
    logic [1:0]  c16;
    logic        busy16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] c;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  c_u;
        logic [1:0]  c_s;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    compare_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy)
    );

    compare_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .c(c16), .busy(busy16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the 4-bit-chunk DUT and leave it waiting in DONE.
    task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv, output int lat);
        int n;
        a = av;
        b = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [15:0] av, input logic [15:0] bv,
                           input logic [1:0] ec, input int el);
        int   lat;
        exp_t e;
        exp_q.push_back('{c: ec, lat: el});
        start_and_wait(av, bv, lat);
        e = exp_q.pop_front();
        chk({name, "_c"}, 32'(c), 32'(e.c));
        chk({name, "_lat"}, 32'(lat), 32'(e.lat));
        chk({name, "_busy"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_clr_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_clr_c"}, 32'(c), 32'd0);
        chk({name, "_clr_ready"}, 32'(in_ready), 32'd1);
        $display("op %s a=%h b=%h c=%b lat=%0d", name, av, bv, ec, lat);
    endtask

    initial begin
        int          lat;
        int          n;
        logic [1:0]  held_c;
        logic [1:0]  ec;

        vecs[0] = '{a: 16'h1234, b: 16'h1234, c_u: 2'b01, c_s: 2'b01, lat: 5};
        vecs[1] = '{a: 16'h8000, b: 16'h0001, c_u: 2'b10, c_s: 2'b11, lat: 2};
        vecs[2] = '{a: 16'h0000, b: 16'h0001, c_u: 2'b11, c_s: 2'b11, lat: 5};
        vecs[3] = '{a: 16'h00F1, b: 16'h00F0, c_u: 2'b10, c_s: 2'b10, lat: 5};
        vecs[4] = '{a: 16'hFFFF, b: 16'h0000, c_u: 2'b10, c_s: 2'b11, lat: 2};
        vecs[5] = '{a: 16'h1200, b: 16'h1300, c_u: 2'b11, c_s: 2'b11, lat: 3};
        vecs[6] = '{a: 16'h7FFF, b: 16'h8000, c_u: 2'b11, c_s: 2'b10, lat: 2};
        vecs[7] = '{a: 16'hABCD, b: 16'hABCE, c_u: 2'b11, c_s: 2'b11, lat: 5};

        rst_n = 1'b0; in_valid = 1'b1; a = 16'h0; b = 16'h0; out_ready = 1'b0;
        rst16_n = 1'b0; in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0; out_ready16 = 1'b0;

        // Reset held with in_valid asserted.
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        rst16_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        $display("op reset in_ready=%b", in_ready);

        for (int i = 0; i < 8; i++) begin
`ifdef COMPARE_SIGNED_EN
            ec = vecs[i].c_s;
`else
            ec = vecs[i].c_u;
`endif
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, ec, vecs[i].lat);
        end

        // Output backpressure: result held for 3 cycles.
        start_and_wait(16'h0000, 16'h0001, lat);
        held_c = c;
        chk("bp_c_first", 32'(held_c), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_c", 32'(c), 32'(held_c));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_rel_valid", 32'(out_valid), 32'd0);
        chk("bp_rel_c", 32'(c), 32'd0);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        $display("op backpressure c=%b", held_c);

        // Reset in the middle of a 4-chunk run must abandon it.
        a = 16'h1234; b = 16'h1234; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("midrst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) n++;
            step();
        end
        chk("midrst_no_valid", 32'(n), 32'd0);
        chk("midrst_c", 32'(c), 32'd0);
        $display("op midrun_reset valid_cycles=%0d", n);

        // Single-chunk instance: reset during RUN, then a fresh equal pair.
        a16 = 16'd1; b16 = 16'd2; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        chk("c16_run_busy", 32'(busy16), 32'd1);
        rst16_n = 1'b0;
        step();
        rst16_n = 1'b1;
        chk("c16_rst_valid", 32'(out_valid16), 32'd0);
        chk("c16_rst_c", 32'(c16), 32'd0);
        exp_q.push_back('{c: 2'b01, lat: 2});
        a16 = 16'd5; b16 = 16'd5; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 20) begin
            step();
            lat++;
        end
        begin
            exp_t e;
            e = exp_q.pop_front();
            chk("c16_valid", 32'(out_valid16), 32'd1);
            chk("c16_c", 32'(c16), 32'(e.c));
            chk("c16_lat", 32'(lat), 32'(e.lat));
        end
        out_ready16 = 1'b1;
        step();
        out_ready16 = 1'b0;
        chk("c16_clr_c", 32'(c16), 32'd0);
        $display("op chunk16 a=5 b=5 lat=%0d", lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
